// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: program-counter and instruction-fetch sequencer.
// Owns the architectural PC and issues one fetch at a time over a valid/ready
// request with a single-cycle response pulse. It holds each fetched
// instruction for the datapath until it is acknowledged. It then advances the
// PC to pc+4 or to the branch target.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr    fetch request channel
//   imem_rsp_valid/data                fetch response (single-cycle pulse)
//   instr_valid, instr, pc             instruction presented to the datapath
//   instr_ack, branch, zero_flag, pc_branch  execution result from datapath
//   misalign_err      sticky: taken branch target was not word-aligned
//   instret           count of acknowledged instructions
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [31:0]          imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 instr_valid,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  input  logic                 instr_ack,
  input  logic                 branch,
  input  logic                 zero_flag,
  input  logic [31:0]          pc_branch,
  output logic                 misalign_err,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {StBoot, StReq, StWait, StExec, StHalt} state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  req_valid_q, req_valid_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  misalign_q, misalign_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  logic                  take;

  assign take = branch & zero_flag;

  // Output flags are registered alongside the state so they line up with it:
  // req_valid is set on entry to REQ and instr_valid on entry to EXEC.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    req_valid_d   = req_valid_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    instret_d     = instret_q;
    unique case (state_q)
      StBoot: begin
        state_d     = StReq;
        req_valid_d = 1'b1;
      end
      StReq: begin
        if (imem_req_ready) begin
          state_d     = StWait;
          req_valid_d = 1'b0;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          state_d       = StExec;
          instr_d       = imem_rsp_data;
          instr_valid_d = 1'b1;
        end
      end
      StExec: begin
        if (instr_ack) begin
          instret_d     = instret_q + INSTRET_W'(1);
          instr_valid_d = 1'b0;
          if (take && (pc_branch[1:0] != 2'b00)) begin
            // Faulting PC is kept so it can be inspected after the halt.
            state_d    = StHalt;
            misalign_d = 1'b1;
          end else begin
            state_d     = StReq;
            req_valid_d = 1'b1;
            pc_d        = take ? pc_branch : (pc_q + 32'd4);
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d       = StHalt;
        req_valid_d   = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      instret_q     <= instret_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign misalign_err   = misalign_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] instr, pc;
  logic        instr_ack = 1'b0, branch = 1'b0, zero_flag = 1'b0;
  logic [31:0] pc_branch = 32'h0;
  logic        misalign_err;
  logic [31:0] instret;

  // Second instance with a reset PC at the top of the address space.
  logic        w_rst = 1'b1;
  logic        w_req_valid, w_req_ready = 1'b0;
  logic [31:0] w_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = 32'h0;
  logic        w_instr_valid;
  logic [31:0] w_instr, w_pc;
  logic        w_ack = 1'b0;
  logic        w_misalign;
  logic [31:0] w_instret;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;

  pc_fetch_seq #(.RESET_PC(32'h0000_0000), .INSTRET_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .instr_ack(instr_ack), .branch(branch), .zero_flag(zero_flag), .pc_branch(pc_branch),
    .misalign_err(misalign_err), .instret(instret)
  );

  pc_fetch_seq #(.RESET_PC(32'hFFFF_FFFC), .INSTRET_W(32)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr(w_instr), .pc(w_pc),
    .instr_ack(w_ack), .branch(1'b0), .zero_flag(1'b0), .pc_branch(32'h0),
    .misalign_err(w_misalign), .instret(w_instret)
  );

  typedef struct {
    logic [31:0] addr;
    int          rdy_dly;
    int          rsp_dly;
    int          ack_dly;
    logic [31:0] data;
    logic        br;
    logic        zf;
    logic [31:0] tgt;
    logic [31:0] next_pc;
    logic        halt;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_fetch(input vec_t v, input int exp_instret);
    bit ok;
    wait_req(ok);
    chk("req_seen", 32'(ok), 32'd1);
    chk("req_addr", imem_addr, v.addr);
    chk("ivalid_in_req", 32'(instr_valid), 32'd0);
    for (int i = 0; i < v.rdy_dly; i++) begin
      step();
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_addr_stable", imem_addr, v.addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_req_low", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < v.rsp_dly; i++) begin
      step();
      chk("wait_ivalid_low", 32'(instr_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = v.data;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hBAD0_BAD0;
    chk("exec_ivalid", 32'(instr_valid), 32'd1);
    chk("exec_instr", instr, v.data);
    chk("exec_pc", pc, v.addr);
    for (int i = 0; i < v.ack_dly; i++) begin
      step();
      chk("hold_instr", instr, v.data);
      chk("hold_ivalid", 32'(instr_valid), 32'd1);
    end
    instr_ack = 1'b1;
    branch    = v.br;
    zero_flag = v.zf;
    pc_branch = v.tgt;
    step();
    instr_ack = 1'b0;
    branch    = 1'b0;
    zero_flag = 1'b0;
    pc_branch = 32'h0;
    chk("post_ack_ivalid", 32'(instr_valid), 32'd0);
    chk("next_pc", pc, v.next_pc);
    chk("instret", instret, 32'(exp_instret));
    chk("misalign", 32'(misalign_err), 32'(v.halt));
    chk("post_ack_req", 32'(imem_req_valid), 32'(!v.halt));
  endtask

  initial begin
    bit ok;
    int exp_ir = 0;
    //          addr          rdy rsp ack data           br  zf  tgt           next          halt
    vecs[0] = '{32'h0000_0000, 0, 0, 1, 32'h0000_0013, 0, 0, 32'h0000_0000, 32'h0000_0004, 0};
    vecs[1] = '{32'h0000_0004, 0, 0, 1, 32'h0010_0093, 0, 0, 32'h0000_0000, 32'h0000_0008, 0};
    vecs[2] = '{32'h0000_0008, 0, 0, 1, 32'h0020_8133, 1, 1, 32'h0000_0010, 32'h0000_0010, 0};
    vecs[3] = '{32'h0000_0010, 0, 0, 0, 32'h0200_0063, 1, 1, 32'h0000_0040, 32'h0000_0040, 0};
    vecs[4] = '{32'h0000_0040, 0, 0, 0, 32'hFC00_08E3, 1, 1, 32'h0000_0010, 32'h0000_0010, 0};
    vecs[5] = '{32'h0000_0010, 0, 0, 0, 32'h0200_0063, 1, 0, 32'h0000_0040, 32'h0000_0014, 0};
    vecs[6] = '{32'h0000_0014, 4, 3, 2, 32'h1234_5678, 0, 1, 32'h0000_0080, 32'h0000_0018, 0};
    vecs[7] = '{32'h0000_0018, 1, 1, 0, 32'h0000_0033, 0, 0, 32'h0000_0022, 32'h0000_001C, 0};
    vecs[8] = '{32'h0000_001C, 0, 0, 0, 32'h0000_1063, 1, 1, 32'h0000_0022, 32'h0000_001C, 1};

    // Reset state.
    step();
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_instret", instret, 32'h0);
    rst = 1'b0;
    step();
    chk("boot_to_req", 32'(imem_req_valid), 32'd1);

    for (int i = 0; i < 9; i++) begin
      exp_ir++;
      do_fetch(vecs[i], exp_ir);
    end
    chk("one_req_per_instr", 32'(req_cnt), 32'd9);

    // HALT ignores every input and stays put.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    instr_ack      = 1'b1;
    branch         = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_req", 32'(imem_req_valid), 32'd0);
      chk("halt_ivalid", 32'(instr_valid), 32'd0);
      chk("halt_pc", pc, 32'h0000_001C);
      chk("halt_misalign", 32'(misalign_err), 32'd1);
      chk("halt_instret", instret, 32'd9);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ack      = 1'b0;

    // Reset out of HALT, then reset again while a fetch is in WAIT.
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_req(ok);
    chk("rehalt_req_seen", 32'(ok), 32'd1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("wrst_pc", pc, 32'h0);
    chk("wrst_instr", instr, 32'h0);
    rst = 1'b0;
    // Stale response during the BOOT cycle must not load instr.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("stale_instr", instr, 32'h0);
    chk("stale_ivalid", 32'(instr_valid), 32'd0);
    chk("stale_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stale_addr", imem_addr, 32'h0);
    chk("stale_misalign", 32'(misalign_err), 32'd0);
    chk("stale_instret", instret, 32'h0);
    step();
    chk("stale_instr_req", instr, 32'h0);

    // PC wrap from RESET_PC = 0xFFFF_FFFC.
    w_rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = w_req_valid;
    end
    chk("wrap_req_seen", 32'(ok), 32'd1);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b1;
    step();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = 32'h0000_0013;
    step();
    w_rsp_valid = 1'b0;
    chk("wrap_ivalid", 32'(w_instr_valid), 32'd1);
    chk("wrap_instr", w_instr, 32'h0000_0013);
    w_ack = 1'b1;
    step();
    w_ack = 1'b0;
    chk("wrap_req", 32'(w_req_valid), 32'd1);
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    chk("wrap_instret", w_instret, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
